// File: rtl/i2c_byte_ctrl.sv
// i2c_byte_ctrl: byte-level master sequencer that turns one request into PHY bit commands.
// Ports: req_* request handshake and fields, done/rx_data/rx_ack/al_o results, busy status,
//        phy_cmd/phy_din towards the bit PHY, phy_ack/phy_dout/phy_al back from it.
// Each PHY command is held until phy_ack; the cycle after an ack always drives NOP, so the PHY
// never sees a stale command, and the next command of the byte is issued one cycle later.
module i2c_byte_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_start,
    input  logic       req_write,
    input  logic       req_read,
    input  logic       req_stop,
    input  logic       req_nack,
    input  logic [7:0] req_wdata,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       rx_ack,
    output logic       al_o,
    output logic       busy,
    output logic [3:0] phy_cmd,
    output logic       phy_din,
    input  logic       phy_ack,
    input  logic       phy_dout,
    input  logic       phy_al
);

    localparam logic [3:0] CMD_NOP   = 4'h0;
    localparam logic [3:0] CMD_START = 4'h1;
    localparam logic [3:0] CMD_STOP  = 4'h2;
    localparam logic [3:0] CMD_WRITE = 4'h4;
    localparam logic [3:0] CMD_READ  = 4'h8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WRITE,
        S_READ,
        S_ACK,
        S_STOP
    } state_t;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       l_read;
    logic       l_write;
    logic       l_stop;
    logic       l_nack;

    state_t     accept_state;
    state_t     post_start;

    // Next phase after START (or directly after accept): read wins over write.
    // S_IDLE here means "nothing left to do, finish".
    function automatic state_t byte_state(input logic rd, input logic wr, input logic st);
        if (rd)
            return S_READ;
        else if (wr)
            return S_WRITE;
        else if (st)
            return S_STOP;
        return S_IDLE;
    endfunction

    // Command for a state; the ACK bit is a READ after a write and a WRITE after a read.
    function automatic logic [3:0] cmd_for(input state_t s, input logic rd);
        case (s)
            S_START: return CMD_START;
            S_WRITE: return CMD_WRITE;
            S_READ:  return CMD_READ;
            S_ACK:   return rd ? CMD_WRITE : CMD_READ;
            S_STOP:  return CMD_STOP;
            default: return CMD_NOP;
        endcase
    endfunction

    // Data bit for a state; idle-high whenever the command does not drive SDA.
    function automatic logic din_for(input state_t s, input logic rd, input logic nack,
                                     input logic msb);
        case (s)
            S_WRITE: return msb;
            S_ACK:   return rd ? nack : 1'b1;
            default: return 1'b1;
        endcase
    endfunction

    assign accept_state = req_start ? S_START : byte_state(req_read, req_write, req_stop);
    assign post_start   = byte_state(l_read, l_write, l_stop);
    assign busy         = ~req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            phy_cmd   <= CMD_NOP;
            phy_din   <= 1'b1;
            done      <= 1'b0;
            rx_data   <= 8'h00;
            rx_ack    <= 1'b1;
            al_o      <= 1'b0;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            l_read    <= 1'b0;
            l_write   <= 1'b0;
            l_stop    <= 1'b0;
            l_nack    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // req_ready stays low in the done cycle and rises one cycle later.
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        al_o      <= 1'b0;
                        l_read    <= req_read;
                        l_write   <= req_write & ~req_read;
                        l_stop    <= req_stop;
                        l_nack    <= req_nack;
                        shift     <= req_wdata;
                        bit_cnt   <= 3'd7;
                        state     <= accept_state;
                        phy_cmd   <= cmd_for(accept_state, req_read);
                        phy_din   <= din_for(accept_state, req_read, req_nack, req_wdata[7]);
                        if (accept_state == S_IDLE)
                            done <= 1'b1;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    if (phy_al) begin
                        // Arbitration lost: abandon the byte, results stay as they were.
                        state   <= S_IDLE;
                        phy_cmd <= CMD_NOP;
                        phy_din <= 1'b1;
                        done    <= 1'b1;
                        al_o    <= 1'b1;
                    end else if (phy_cmd == CMD_NOP) begin
                        // Gap cycle after an ack: issue the command for the current phase.
                        phy_cmd <= cmd_for(state, l_read);
                        phy_din <= din_for(state, l_read, l_nack, shift[7]);
                    end else if (phy_ack) begin
                        phy_cmd <= CMD_NOP;
                        phy_din <= 1'b1;
                        case (state)
                            S_START: begin
                                bit_cnt <= 3'd7;
                                if (post_start == S_IDLE) begin
                                    state <= S_IDLE;
                                    done  <= 1'b1;
                                end else begin
                                    state <= post_start;
                                end
                            end
                            S_WRITE, S_READ: begin
                                if (state == S_WRITE)
                                    shift <= {shift[6:0], 1'b0};
                                else
                                    shift <= {shift[6:0], phy_dout};
                                if (bit_cnt == 3'd0)
                                    state <= S_ACK;
                                else
                                    bit_cnt <= bit_cnt - 3'd1;
                            end
                            S_ACK: begin
                                // Results commit only once the ACK bit completes cleanly.
                                if (l_read)
                                    rx_data <= shift;
                                else
                                    rx_ack <= phy_dout;
                                if (l_stop) begin
                                    state <= S_STOP;
                                end else begin
                                    state <= S_IDLE;
                                    done  <= 1'b1;
                                end
                            end
                            default: begin
                                state <= S_IDLE;
                                done  <= 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// tb_i2c_byte_ctrl: directed plus randomized transactions against a PHY model with a
// fixed ack latency; expected command lists and results come from a list-based reference.
`timescale 1ns/1ps
module tb_i2c_byte_ctrl;

    localparam logic [3:0] C_NOP   = 4'h0;
    localparam logic [3:0] C_START = 4'h1;
    localparam logic [3:0] C_STOP  = 4'h2;
    localparam logic [3:0] C_WRITE = 4'h4;
    localparam logic [3:0] C_READ  = 4'h8;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req_valid, req_ready, req_start, req_write, req_read, req_stop, req_nack;
    logic [7:0] req_wdata;
    logic       done, rx_ack, al_o, busy;
    logic [7:0] rx_data;
    logic [3:0] phy_cmd;
    logic       phy_din, phy_ack, phy_dout, phy_al;

    i2c_byte_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_start(req_start), .req_write(req_write), .req_read(req_read),
        .req_stop(req_stop), .req_nack(req_nack), .req_wdata(req_wdata),
        .done(done), .rx_data(rx_data), .rx_ack(rx_ack), .al_o(al_o), .busy(busy),
        .phy_cmd(phy_cmd), .phy_din(phy_din),
        .phy_ack(phy_ack), .phy_dout(phy_dout), .phy_al(phy_al)
    );

    int checks = 0;
    int failures = 0;

    // PHY model state
    bit         pbusy;
    bit         ack_drv;
    int         pcnt;
    logic [3:0] pcmd;
    int         cyc;
    int         last_ack_cyc;
    int         al_at;
    logic [4:0] issued_q[$];
    bit         dout_q[$];

    // Reference results carried across transactions
    logic [7:0] ref_rx;
    logic       ref_rx_ack;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ":phy_cmd"},   phy_cmd,   C_NOP);
        check({tag, ":phy_din"},   phy_din,   1);
        check({tag, ":done"},      done,      0);
        check({tag, ":rx_data"},   rx_data,   0);
        check({tag, ":rx_ack"},    rx_ack,    1);
        check({tag, ":al_o"},      al_o,      0);
        check({tag, ":req_ready"}, req_ready, 1);
        check({tag, ":busy"},      busy,      0);
    endtask

    task automatic phy_reset();
        pbusy   = 0;
        ack_drv = 0;
        pcnt    = 0;
        phy_ack = 0;
        phy_al  = 0;
    endtask

    // One PHY cycle, evaluated at the falling edge.
    task automatic phy_step();
        if (ack_drv) begin
            ack_drv = 0;
            phy_ack = 0;
            phy_al  = 0;
            pbusy   = 0;
            check("cmd_changed_after_ack", phy_cmd !== pcmd, 1);
        end else if (pbusy) begin
            check("cmd_hold", phy_cmd, pcmd);
            if (pcnt == 0) begin
                ack_drv      = 1;
                phy_ack      = 1;
                last_ack_cyc = cyc;
                if (pcmd == C_READ)
                    phy_dout = (dout_q.size() > 0) ? dout_q.pop_front() : ($urandom_range(0, 1) == 1);
                if (issued_q.size() - 1 == al_at)
                    phy_al = 1;
            end else begin
                pcnt--;
            end
        end
        if (!pbusy && phy_cmd != C_NOP) begin
            pbusy = 1;
            pcmd  = phy_cmd;
            pcnt  = 4;
            issued_q.push_back({phy_din, phy_cmd});
        end
    endtask

    task automatic run_txn(input bit st, input bit wr, input bit rd, input bit sp, input bit nk,
                           input logic [7:0] wd, input logic [7:0] sb, input bit sn,
                           input int al_idx, input int rst_at, input string tag);
        logic [4:0] exp_q[$];
        int         done_cnt;
        int         done_cyc;
        int         w;
        int         ack_idx;
        bit         aborted;
        bit         finished;
        logic [7:0] d_rx;
        logic       d_ack, d_al;
        logic [3:0] d_cmd;

        // Reference: the command list the byte should produce
        exp_q.delete();
        dout_q.delete();
        issued_q.delete();
        phy_reset();
        if (st) exp_q.push_back({1'b1, C_START});
        if (rd) begin
            for (int i = 7; i >= 0; i--) begin
                exp_q.push_back({1'b1, C_READ});
                dout_q.push_back(sb[i]);
            end
            exp_q.push_back({nk, C_WRITE});
        end else if (wr) begin
            for (int i = 7; i >= 0; i--) exp_q.push_back({wd[i], C_WRITE});
            exp_q.push_back({1'b1, C_READ});
            dout_q.push_back(sn);
        end
        if (sp) exp_q.push_back({1'b1, C_STOP});
        aborted = (al_idx >= 0) && (al_idx < exp_q.size());
        al_at   = aborted ? al_idx : -1;
        while (aborted && exp_q.size() > al_idx + 1) void'(exp_q.pop_back());
        ack_idx = (st ? 1 : 0) + 8;
        if (!aborted || al_idx > ack_idx) begin
            if (rd) ref_rx = sb;
            else if (wr) ref_rx_ack = sn;
        end

        // Handshake
        w = 0;
        while (req_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, ":ready"}, req_ready, 1);
        req_start = st; req_write = wr; req_read = rd; req_stop = sp;
        req_nack  = nk; req_wdata = wd; req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        check({tag, ":al_clear"}, al_o, 0);
        check({tag, ":busy"}, busy, 1);

        done_cnt = 0;
        done_cyc = -1;
        d_rx = 0; d_ack = 0; d_al = 0; d_cmd = 0;
        cyc = 1;
        finished = 0;
        while (!finished) begin
            if (rst_at > 0 && cyc == rst_at) begin
                rst = 1;
                phy_reset();
                @(negedge clk);
                check_reset_vals({tag, ":rst"});
                rst = 0;
                ref_rx = 8'h00;
                ref_rx_ack = 1'b1;
                repeat (20) begin
                    @(negedge clk);
                    if (done === 1'b1) done_cnt++;
                end
                check({tag, ":no_done"}, done_cnt, 0);
                check({tag, ":idle_cmd"}, phy_cmd, C_NOP);
                return;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    d_rx = rx_data; d_ack = rx_ack; d_al = al_o; d_cmd = phy_cmd;
                end
            end
            if (done_cnt > 0 && cyc >= done_cyc + 3) begin
                finished = 1;
            end else if (cyc >= 400) begin
                finished = 1;
            end else begin
                phy_step();
                @(negedge clk);
                cyc++;
            end
        end

        check({tag, ":done_count"}, done_cnt, 1);
        check({tag, ":done_time"}, done_cyc, (exp_q.size() == 0) ? 1 : last_ack_cyc + 1);
        check({tag, ":ncmds"}, issued_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < issued_q.size(); i++) begin
            check({tag, ":cmd"}, issued_q[i][3:0], exp_q[i][3:0]);
            if (exp_q[i][3:0] == C_WRITE)
                check({tag, ":din"}, issued_q[i][4], exp_q[i][4]);
        end
        check({tag, ":rx_data"}, d_rx, ref_rx);
        check({tag, ":rx_ack"}, d_ack, ref_rx_ack);
        check({tag, ":al_o"}, d_al, aborted);
        check({tag, ":cmd_at_done"}, d_cmd, C_NOP);
        check({tag, ":ready_after"}, req_ready, 1);
    endtask

    initial begin
        rst = 1; req_valid = 0; req_start = 0; req_write = 0; req_read = 0;
        req_stop = 0; req_nack = 0; req_wdata = 8'h00;
        phy_ack = 0; phy_dout = 1; phy_al = 0;
        ref_rx = 8'h00; ref_rx_ack = 1'b1;
        al_at = -1; last_ack_cyc = 0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 0;
        @(negedge clk);

        run_txn(1, 1, 0, 1, 0, 8'hA5, 8'h00, 0, -1, 0, "start_write_stop");
        run_txn(0, 0, 1, 0, 1, 8'h00, 8'h3C, 0, -1, 0, "read_nack");
        run_txn(0, 1, 0, 0, 0, 8'hFF, 8'h00, 1, -1, 0, "write_slave_nack");
        run_txn(1, 1, 0, 0, 0, 8'h5A, 8'h00, 0, 4, 0, "al_4th_bit");
        repeat (5) @(negedge clk);
        check("al_held", al_o, 1);
        run_txn(0, 0, 0, 1, 0, 8'h00, 8'h00, 0, -1, 0, "stop_only");
        run_txn(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, -1, 0, "empty");
        run_txn(0, 0, 1, 1, 0, 8'h00, 8'h96, 0, -1, 20, "rst_mid_read");

        for (int n = 0; n < 25; n++) begin
            run_txn($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom),
                    $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 11)) : -1,
                    0, "random");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
